time_surface_encoder_mc: RTL and testbench

Multi-channel, scan-driven time-surface encoder for the gradient-map architecture. Stores the last-event timestamp for each (channel, grid cell) pair, typically one channel per DVS polarity. On request it streams every cell's decayed surface value through a valid/ready port, all computed against one snapshotted reference time. Sits between the event decoder and the feature-extraction/flatten stage, and owns its own dual-port timestamp storage.

---
 rtl/time_surface_encoder_mc.sv | 264 ++++++++++++++++++++++++++
 tb/tb_time_surface_encoder_mc.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_surface_encoder_mc.sv
// -----------------------------------------------------------------------------
// time_surface_encoder_mc
//
// Multi-channel time-surface encoder. Keeps the most recent event timestamp and
// a valid bit for every (channel, grid cell) entry. A scan snapshots t_now and
// streams every entry's decayed surface value out through a valid/ready port,
// channel-major, address ascending.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   t_now                    global timestamp, latched at scan start
//   event_valid/event_ready  event write handshake (ready low in CLEAR / rst)
//   event_x/y/ch/ts          event coordinates, channel and timestamp
//   clear_req                invalidate every entry (honoured in IDLE only)
//   scan_start               begin a full readout (honoured in IDLE only)
//   scan_busy                scan in progress
//   scan_done                one-cycle pulse after the last beat is accepted
//   out_valid/out_ready      readout handshake
//   out_ch/out_addr          channel and cell address (y*GRID_SIZE+x) of a beat
//   out_value                decayed surface value
//
// Build option
//   TSE_SCAN_AUTOCLEAR_EN    when defined, every completed scan is followed by
//                            a CLEAR cycle so each scan yields a fresh frame.
//
// Readout pipeline: p0 = address issue, p1 = storage read, then the output
// register. The whole pipeline stalls on !out_valid || out_ready being false.
// -----------------------------------------------------------------------------
module time_surface_encoder_mc #(
  parameter  int GRID_SIZE   = 16,
  parameter  int NUM_CH      = 2,
  parameter  int TS_BITS     = 16,
  parameter  int VALUE_BITS  = 8,
  parameter  int MAX_VALUE   = 255,
  parameter  int DECAY_SHIFT = 6,
  parameter  int DECAY_MODE  = 0,
  localparam int XY_W        = $clog2(GRID_SIZE),
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CELLS       = GRID_SIZE * GRID_SIZE,
  localparam int AW          = $clog2(CELLS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TS_BITS-1:0]    t_now,
  input  logic                  event_valid,
  output logic                  event_ready,
  input  logic [XY_W-1:0]       event_x,
  input  logic [XY_W-1:0]       event_y,
  input  logic [CH_W-1:0]       event_ch,
  input  logic [TS_BITS-1:0]    event_ts,
  input  logic                  clear_req,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [AW-1:0]         out_addr,
  output logic [VALUE_BITS-1:0] out_value
);

  localparam int DEPTH = NUM_CH * CELLS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [VALUE_BITS-1:0] MAX_V          = VALUE_BITS'(MAX_VALUE);
  localparam logic [TS_BITS-1:0]    STEP_LIMIT_EXP = TS_BITS'(VALUE_BITS);
  localparam logic [TS_BITS-1:0]    STEP_LIMIT_LIN = TS_BITS'(MAX_VALUE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_CLEAR
  } state_t;

  // Decayed value of one entry against the snapshot time. A wrapped delta in
  // the upper half of the timestamp range means the event is newer than the
  // snapshot, so it is reported as fresh.
  function automatic logic [VALUE_BITS-1:0] decay_value(
    input logic               cell_vld,
    input logic [TS_BITS-1:0] snap,
    input logic [TS_BITS-1:0] ts
  );
    logic [TS_BITS-1:0]    delta;
    logic [TS_BITS-1:0]    steps;
    logic [VALUE_BITS-1:0] val;
    delta = snap - ts;
    steps = delta >> DECAY_SHIFT;
    if (!cell_vld) begin
      val = '0;
    end else if (delta[TS_BITS-1]) begin
      val = MAX_V;
    end else if (DECAY_MODE == 0) begin
      val = (steps >= STEP_LIMIT_EXP) ? '0 : (MAX_V >> steps);
    end else begin
      val = (steps >= STEP_LIMIT_LIN) ? '0 : (MAX_V - VALUE_BITS'(steps));
    end
    return val;
  endfunction

  state_t                  state_q, state_d;
  logic [TS_BITS-1:0]      t_snap_q, t_snap_d;
  logic [CH_W-1:0]         rd_ch_q, rd_ch_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic                    vld_p0_q, vld_p0_d;
  logic                    vld_p1_q, vld_p1_d;
  logic                    out_valid_q, out_valid_d;
  logic [VALUE_BITS-1:0]   out_value_q, out_value_d;
  logic [CH_W-1:0]         out_ch_q, out_ch_d;
  logic [AW-1:0]           out_addr_q, out_addr_d;
  logic                    scan_busy_q, scan_busy_d;
  logic                    scan_done_q, scan_done_d;
  logic [DEPTH-1:0]        cell_vld_q;

  logic [TS_BITS-1:0]      ts_mem [DEPTH];
  logic [TS_BITS-1:0]      ts_p1_q;
  logic                    cell_vld_p1_q;
  logic [CH_W-1:0]         ch_p1_q;
  logic [AW-1:0]           addr_p1_q;

  logic                    advance;
  logic                    ev_acc;
  logic                    issue_last;
  logic                    out_last;
  logic [IW-1:0]           wr_idx;
  logic [IW-1:0]           rd_idx;

  assign event_ready = !rst && (state_q != S_CLEAR);
  // Channel indices beyond NUM_CH (non power-of-two counts) are dropped.
  assign ev_acc      = event_valid && event_ready && (int'(event_ch) < NUM_CH);
  assign wr_idx      = IW'(event_ch) * IW'(CELLS) + IW'({event_y, event_x});
  assign rd_idx      = IW'(rd_ch_q) * IW'(CELLS) + IW'(rd_addr_q);
  assign advance     = !out_valid_q || out_ready;
  assign issue_last  = (rd_ch_q == CH_W'(NUM_CH - 1)) && (rd_addr_q == AW'(CELLS - 1));
  assign out_last    = (out_ch_q == CH_W'(NUM_CH - 1)) && (out_addr_q == AW'(CELLS - 1));

  always_comb begin
    state_d     = state_q;
    t_snap_d    = t_snap_q;
    rd_ch_d     = rd_ch_q;
    rd_addr_d   = rd_addr_q;
    vld_p0_d    = vld_p0_q;
    vld_p1_d    = vld_p1_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_ch_d    = out_ch_q;
    out_addr_d  = out_addr_q;
    scan_busy_d = scan_busy_q;
    scan_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
        end else if (scan_start) begin
          state_d     = S_SCAN;
          t_snap_d    = t_now;
          rd_ch_d     = '0;
          rd_addr_d   = '0;
          vld_p0_d    = 1'b1;
          scan_busy_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (advance) begin
          if (issue_last) begin
            vld_p0_d = 1'b0;
            state_d  = S_DRAIN;
          end else if (rd_addr_q == AW'(CELLS - 1)) begin
            rd_addr_d = '0;
            rd_ch_d   = rd_ch_q + CH_W'(1);
          end else begin
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready && out_last) begin
          scan_done_d = 1'b1;
          scan_busy_d = 1'b0;
`ifdef TSE_SCAN_AUTOCLEAR_EN
          state_d     = S_CLEAR;
`else
          state_d     = S_IDLE;
`endif
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // p1 -> output register boundary
    if (advance) begin
      vld_p1_d    = vld_p0_q;
      out_valid_d = vld_p1_q;
      out_value_d = decay_value(cell_vld_p1_q, t_snap_q, ts_p1_q);
      out_ch_d    = ch_p1_q;
      out_addr_d  = addr_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      t_snap_q    <= '0;
      rd_ch_q     <= '0;
      rd_addr_q   <= '0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_ch_q    <= '0;
      out_addr_q  <= '0;
      scan_busy_q <= 1'b0;
      scan_done_q <= 1'b0;
      cell_vld_q  <= '0;
    end else begin
      state_q     <= state_d;
      t_snap_q    <= t_snap_d;
      rd_ch_q     <= rd_ch_d;
      rd_addr_q   <= rd_addr_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_ch_q    <= out_ch_d;
      out_addr_q  <= out_addr_d;
      scan_busy_q <= scan_busy_d;
      scan_done_q <= scan_done_d;
      // A write accepted on the cycle before CLEAR is wiped by CLEAR.
      if (state_q == S_CLEAR) begin
        cell_vld_q <= '0;
      end else if (ev_acc) begin
        cell_vld_q[wr_idx] <= 1'b1;
      end
    end
  end

  // p0 -> p1 boundary: storage read. Non-blocking write means a same-address
  // read in the same cycle sees the previous contents.
  always_ff @(posedge clk) begin
    if (ev_acc) begin
      ts_mem[wr_idx] <= event_ts;
    end
    if (advance) begin
      ts_p1_q       <= ts_mem[rd_idx];
      cell_vld_p1_q <= cell_vld_q[rd_idx];
      ch_p1_q       <= rd_ch_q;
      addr_p1_q     <= rd_addr_q;
    end
  end

  assign scan_busy = scan_busy_q;
  assign scan_done = scan_done_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_addr  = out_addr_q;
  assign out_value = out_value_q;

endmodule

// File: tb/tb_time_surface_encoder_mc.sv
module tb_time_surface_encoder_mc;

  localparam int G     = 16;
  localparam int NCH   = 2;
  localparam int CELLS = G * G;
  localparam int DEPTH = NCH * CELLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] t_now = '0;
  logic        event_valid = 1'b0;
  logic [3:0]  event_x = '0;
  logic [3:0]  event_y = '0;
  logic [0:0]  event_ch = '0;
  logic [15:0] event_ts = '0;
  logic        clear_req = 1'b0;
  logic        scan_start = 1'b0;
  logic        out_ready = 1'b1;

  logic        event_ready, scan_busy, scan_done, out_valid;
  logic [0:0]  out_ch;
  logic [7:0]  out_addr;
  logic [7:0]  out_value;

  logic        event_ready_l, scan_busy_l, scan_done_l, out_valid_l;
  logic [0:0]  out_ch_l;
  logic [7:0]  out_addr_l;
  logic [7:0]  out_value_l;

  always #5 clk = ~clk;

  time_surface_encoder_mc dut (
    .clk(clk), .rst(rst), .t_now(t_now),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_x(event_x), .event_y(event_y), .event_ch(event_ch), .event_ts(event_ts),
    .clear_req(clear_req), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_addr(out_addr), .out_value(out_value)
  );

  time_surface_encoder_mc #(.DECAY_MODE(1)) dut_lin (
    .clk(clk), .rst(rst), .t_now(t_now),
    .event_valid(event_valid), .event_ready(event_ready_l),
    .event_x(event_x), .event_y(event_y), .event_ch(event_ch), .event_ts(event_ts),
    .clear_req(clear_req), .scan_start(scan_start),
    .scan_busy(scan_busy_l), .scan_done(scan_done_l),
    .out_valid(out_valid_l), .out_ready(out_ready),
    .out_ch(out_ch_l), .out_addr(out_addr_l), .out_value(out_value_l)
  );

  typedef struct {
    int ch;
    int addr;
    int v_exp;
    int v_lin;
  } beat_t;

  beat_t       sbq[$];
  logic [15:0] m_ts [DEPTH];
  bit          m_vld [DEPTH];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_acc_cyc  = -1;
  int last_rise_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_val(bit v, int snap, int ts, int mode);
    int d;
    int s;
    if (!v) return 0;
    d = (snap - ts) & 'hFFFF;
    if (d >= 'h8000) return 255;
    s = d / 64;
    if (mode == 0) return (s >= 8) ? 0 : (255 / (1 << s));
    return (s >= 255) ? 0 : 255 - s;
  endfunction

  // Output monitor: pops the scoreboard on every accepted beat and checks
  // that a stalled beat holds its contents.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [0:0]  pch = '0;
  logic [7:0]  paddr = '0;
  logic [7:0]  pval = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_ch",    32'(out_ch),    32'(pch));
        chk("stall_addr",  32'(out_addr),  32'(paddr));
        chk("stall_value", 32'(out_value), 32'(pval));
      end
      if (out_valid && !pv) last_rise_cyc <= cyc;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("beat_ch",    32'(out_ch),      32'(sbq[0].ch));
          chk("beat_addr",  32'(out_addr),    32'(sbq[0].addr));
          chk("beat_exp",   32'(out_value),   32'(sbq[0].v_exp));
          chk("beat_lin",   32'(out_value_l), 32'(sbq[0].v_lin));
          void'(sbq.pop_front());
        end
        last_acc_cyc <= cyc;
      end
    end
    pv    <= out_valid && !rst;
    pr    <= out_ready;
    pch   <= out_ch;
    paddr <= out_addr;
    pval  <= out_value;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  task automatic send_event(input int ch, input int x, input int y, input int ts);
    int idx;
    idx = ch * CELLS + y * G + x;
    event_valid = 1'b1;
    event_ch    = 1'(ch);
    event_x     = 4'(x);
    event_y     = 4'(y);
    event_ts    = 16'(ts);
    @(negedge clk);
    chk("event_ready", 32'(event_ready), 32'd1);
    if (event_ready) begin
      m_ts[idx]  = 16'(ts);
      m_vld[idx] = 1'b1;
    end
    tick();
    event_valid = 1'b0;
  endtask

  task automatic push_expected(input int tnow);
    for (int c = 0; c < NCH; c++) begin
      for (int a = 0; a < CELLS; a++) begin
        sbq.push_back('{c, a,
                        model_val(m_vld[c*CELLS+a], tnow, int'(m_ts[c*CELLS+a]), 0),
                        model_val(m_vld[c*CELLS+a], tnow, int'(m_ts[c*CELLS+a]), 1)});
      end
    end
  endtask

  task automatic run_scan(input int tnow, input int rdy_pct, input string tag, output int start);
    bit done;
    int done_cyc;
    t_now = 16'(tnow);
    push_expected(tnow);
    scan_start = 1'b1;
    out_ready  = 1'b1;
    start = cyc;
    tick();
    scan_start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(scan_busy), 32'd1);
    done = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      tick();
      out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (scan_done) begin
        done = 1'b1;
        done_cyc = cyc;
      end
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_lat"}, 32'(done_cyc), 32'(last_acc_cyc + 1));
    chk({tag, "_left"}, 32'(sbq.size()), 32'd0);
    out_ready = 1'b1;
    tick();
    chk({tag, "_done_pulse"}, 32'(scan_done), 32'd0);
    chk({tag, "_busy_end"}, 32'(scan_busy), 32'd0);
`ifdef TSE_SCAN_AUTOCLEAR_EN
    clear_model();
`endif
  endtask

  initial begin
    int s;
    clear_model();
    for (int i = 0; i < DEPTH; i++) m_ts[i] = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_event_ready", 32'(event_ready), 32'd0);
    chk("rst_out_valid",   32'(out_valid),   32'd0);
    chk("rst_out_value",   32'(out_value),   32'd0);
    chk("rst_out_ch",      32'(out_ch),      32'd0);
    chk("rst_out_addr",    32'(out_addr),    32'd0);
    chk("rst_scan_busy",   32'(scan_busy),   32'd0);
    chk("rst_scan_done",   32'(scan_done),   32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_event_ready", 32'(event_ready), 32'd1);

    // Empty surface, full-rate readout with latency checks
    run_scan(1000, 100, "empty", s);
    chk("first_valid_lat", 32'(last_rise_cyc), 32'(s + 3));
    chk("last_accept_cyc", 32'(last_acc_cyc),  32'(s + 514));

    // Single event, two decay steps
    send_event(1, 3, 2, 100);
    run_scan(230, 100, "decay", s);

    // Linear decay and saturation
    send_event(0, 0, 0, 0);
    run_scan(640, 100, "lin", s);
    run_scan(16383, 100, "lin_sat", s);

    // Timestamp wrap and future events, under random backpressure
    send_event(0, 1, 0, 'hFFF0);
    send_event(1, 5, 5, 'h0100);
    run_scan('h0030, 30, "wrap_bp", s);

    // clear_req beats a simultaneous scan_start
    send_event(0, 7, 7, 'h0020);
    clear_req  = 1'b1;
    scan_start = 1'b1;
    t_now      = 16'h0040;
    tick();
    clear_req  = 1'b0;
    scan_start = 1'b0;
    chk("clear_event_ready", 32'(event_ready), 32'd0);
    chk("clear_no_scan",     32'(scan_busy),   32'd0);
    clear_model();
    tick();
    chk("after_clear_ready", 32'(event_ready), 32'd1);
    chk("after_clear_busy",  32'(scan_busy),   32'd0);
    tick();
    chk("after_clear_valid", 32'(out_valid),   32'd0);
    run_scan('h0040, 100, "post_clear", s);

    // Back-to-back scans over the same events
    send_event(0, 2, 3, 'h0100);
    send_event(1, 15, 15, 'h00C0);
    run_scan('h0180, 100, "b2b_a", s);
    run_scan('h0180, 100, "b2b_b", s);

    // Reset in the middle of a scan
    send_event(1, 0, 1, 'h0200);
    t_now = 16'h0210;
    push_expected('h0210);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    sbq.delete();
    clear_model();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_scan_busy", 32'(scan_busy), 32'd0);
    tick();
    chk("abort_scan_done", 32'(scan_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_idle_valid", 32'(out_valid), 32'd0);
    run_scan('h0300, 100, "post_abort", s);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
